// File: rtl/counter_rr_scheduler.sv
// rtl/counter_rr_scheduler.sv - round-robin sequencer sharing one WIDTH-bit incrementer among N counters
// Optional saturating increment: define COUNTER_RR_SCHEDULER_SATURATE_EN.
module counter_rr_scheduler #(
    parameter int N     = 4,
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         CLR,
    output logic [N-1:0]         GNT,
    output logic                 VALID,
    output logic [$clog2(N)-1:0] ID,
    output logic [WIDTH-1:0]     O,
    output logic                 COUT
);
    localparam int IW = $clog2(N);

    logic [WIDTH-1:0] count_q [N];
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             valid_q;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;

    logic [N-1:0]     elig;
    logic             gnt_any;
    logic [IW-1:0]    gnt_idx;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   sum;
    int               idx;

    // Search starts at ptr_q and wraps; the first eligible requester wins.
    always_comb begin
        elig    = REQ & ~CLR & {N{EN & ~RESET}};
        GNT     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && elig[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = IW'(idx);
                GNT[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        cur = count_q[gnt_idx];
        sum = {1'b0, cur} + (WIDTH+1)'(1);
`ifdef COUNTER_RR_SCHEDULER_SATURATE_EN
        if (&cur) begin
            o_d    = cur;
            cout_d = 1'b1;
        end else begin
            o_d    = sum[WIDTH-1:0];
            cout_d = 1'b0;
        end
`else
        o_d    = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
`endif
        ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end

    // CLR is written last so it wins; a cleared requester is never granted anyway.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) count_q[i] <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            o_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= gnt_any;
            if (gnt_any) begin
                count_q[gnt_idx] <= o_d;
                ptr_q            <= ptr_d;
                id_q             <= gnt_idx;
                o_q              <= o_d;
                cout_q           <= cout_d;
            end
            for (int i = 0; i < N; i++) begin
                if (CLR[i]) count_q[i] <= '0;
            end
        end
    end

    assign VALID = valid_q;
    assign ID    = id_q;
    assign O     = o_q;
    assign COUT  = cout_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// tb/tb_counter_rr_scheduler.sv - scoreboard bench for counter_rr_scheduler
// Honours COUNTER_RR_SCHEDULER_SATURATE_EN in its reference model.
module tb_counter_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          EN = 1'b0;
    logic [N-1:0]  REQ = '0;
    logic [N-1:0]  CLR = '0;
    logic [N-1:0]  GNT;
    logic          VALID;
    logic [IW-1:0] ID;
    logic [W-1:0]  O;
    logic          COUT;

    counter_rr_scheduler #(.N(N), .WIDTH(W)) dut (
        .CLK(clk), .RESET(RESET), .EN(EN), .REQ(REQ), .CLR(CLR),
        .GNT(GNT), .VALID(VALID), .ID(ID), .O(O), .COUT(COUT)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int           m_cnt [N];
    int           m_ptr = 0;
    logic         m_valid = 1'b0;
    int           m_id = 0, m_o = 0, m_cout = 0;
    logic [31:0]  exp_q [$];

    function automatic int model_pick(input logic [N-1:0] req, input logic [N-1:0] clr,
                                      input logic en, input logic rst);
        int j;
        if (rst || !en) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req[j] && !clr[j]) return j;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] clr,
                        input logic en, input logic rst);
        int gi, s, c;
        logic [31:0] e;
        logic [N-1:0] eg;
        @(negedge clk);
        REQ = req; CLR = clr; EN = en; RESET = rst;
        #1;
        gi = model_pick(req, clr, en, rst);
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        check_eq("gnt", 32'(GNT), 32'(eg));
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr = 0; m_valid = 1'b0; m_id = 0; m_o = 0; m_cout = 0;
            exp_q.delete();
        end else begin
            if (gi >= 0) begin
`ifdef COUNTER_RR_SCHEDULER_SATURATE_EN
                if (m_cnt[gi] == (1 << W) - 1) begin s = m_cnt[gi]; c = 1; end
                else begin s = m_cnt[gi] + 1; c = 0; end
`else
                s = (m_cnt[gi] + 1) % (1 << W);
                c = (m_cnt[gi] == (1 << W) - 1) ? 1 : 0;
`endif
                m_cnt[gi] = s;
                m_ptr = (gi + 1) % N;
                e = (gi << 16) | (s << 1) | c;
                exp_q.push_back(e);
            end
            for (int i = 0; i < N; i++) if (clr[i]) m_cnt[i] = 0;
            m_valid = (gi >= 0);
        end
        @(posedge clk);
        #1;
        check_eq("valid", 32'(VALID), 32'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                m_id = int'(e[31:16]); m_o = int'(e[15:1]); m_cout = int'(e[0]);
            end
        end
        check_eq("id", 32'(ID), 32'(m_id));
        check_eq("o", 32'(O), 32'(m_o));
        check_eq("cout", 32'(COUT), 32'(m_cout));
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        // 1: reset with all requesting
        step(4'hF, 4'h0, 1'b1, 1'b1);
        step(4'hF, 4'h0, 1'b1, 1'b1);
        // 2: single requester
        for (int i = 0; i < 3; i++) step(4'b0100, 4'h0, 1'b1, 1'b0);
        check_eq("t2_o3", 32'(O), 32'd3);
        // 3: round-robin from reset
        step(4'h0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(4'hF, 4'h0, 1'b1, 1'b0);
        check_eq("t3_id", 32'(ID), 32'd3);
        check_eq("t3_o", 32'(O), 32'd2);
        // 4: wrap / saturate on requester 0
        step(4'h0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(4'b0001, 4'h0, 1'b1, 1'b0);
`ifdef COUNTER_RR_SCHEDULER_SATURATE_EN
        check_eq("t4_o16", 32'(O), 32'd15);
`else
        check_eq("t4_o16", 32'(O), 32'd0);
`endif
        check_eq("t4_c16", 32'(COUT), 32'd1);
        step(4'b0001, 4'h0, 1'b1, 1'b0);
        // 5: clear collision with ptr back at 0 and count0 nonzero
        step(4'h0, 4'h0, 1'b1, 1'b1);
        step(4'b0001, 4'h0, 1'b1, 1'b0);
        step(4'b1000, 4'h0, 1'b1, 1'b0);
        step(4'b0011, 4'b0001, 1'b1, 1'b0);
        check_eq("t5_id", 32'(ID), 32'd1);
        step(4'b0001, 4'h0, 1'b1, 1'b0);
        check_eq("t5_cnt0", 32'(O), 32'd1);
        // 6: mid-stream reset, then EN low (CLR still acts)
        for (int i = 0; i < 3; i++) step(4'hF, 4'h0, 1'b1, 1'b0);
        step(4'hF, 4'h0, 1'b1, 1'b1);
        step(4'hF, 4'h0, 1'b1, 1'b0);
        step(4'hF, 4'h0, 1'b1, 1'b0);
        step(4'hF, 4'h0, 1'b0, 1'b0);
        step(4'hF, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'hF, 4'h0, 1'b1, 1'b0);
        // random mix
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 60) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
